bit_serial_alu: RTL and testbench

BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

---
 rtl/bit_serial_alu_pkg.sv | 20 ++
 rtl/bit_serial_alu_slice.sv | 25 ++
 rtl/bit_serial_alu.sv | 123 ++++++++++++
 tb/tb_bit_serial_alu.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings and FSM states.
// op[3] inverts A, op[2] inverts B with carry-in 1, op[1:0] picks the function.
package bit_serial_alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT_S = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_alu_slice.sv
// One-bit combinational ALU slice: optional operand inversion,
// generate/propagate terms and a full adder.
module alu_bit_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic inv_a,
    input  logic inv_b,
    output logic g,
    output logic p,
    output logic sum,
    output logic cout
);

    logic ai;
    logic bi;

    assign ai   = a ^ inv_a;
    assign bi   = b ^ inv_b;
    assign g    = ai & bi;
    assign p    = ai | bi;
    assign sum  = ai ^ bi ^ cin;
    assign cout = (ai & bi) | (ai & cin) | (bi & cin);

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one result bit per clock, LSB first, through a single slice.
// Result, flags and zero are registered and held until the next accepted start.
module bit_serial_alu
    import bit_serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             ovf
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;

    logic             s_g;
    logic             s_p;
    logic             s_sum;
    logic             s_cout;
    logic             last;
    logic             res_bit;
    logic [WIDTH-1:0] res_next;

    alu_bit_slice u_slice (
        .a     (a_q[idx]),
        .b     (b_q[idx]),
        .cin   (carry),
        .inv_a (op_q[3]),
        .inv_b (op_q[2]),
        .g     (s_g),
        .p     (s_p),
        .sum   (s_sum),
        .cout  (s_cout)
    );

    assign last = (idx == LAST);
    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SLT writes zeros serially; the set bit lands in bit 0 on the last cycle.
    always_comb begin
        unique case (op_q[1:0])
            OP_AND:  res_bit = s_g;
            OP_OR:   res_bit = s_p;
            OP_ADD:  res_bit = s_sum;
            default: res_bit = 1'b0;
        endcase
        res_next = result;
        res_next[idx] = res_bit;
        if (last && op_q[1:0] == OP_SLT) begin
            res_next[0] = s_sum ^ (carry ^ s_cout);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            result <= '0;
            zero   <= 1'b1;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op;
                idx   <= '0;
                carry <= op[2];
            end
            if (state == RUN) begin
                carry  <= s_cout;
                result <= res_next;
                if (last) begin
                    cout <= s_cout;
                    ovf  <= carry ^ s_cout;
                    zero <= (res_next == '0);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Randomized and directed self-checking bench for bit_serial_alu,
// compared against an arithmetic reference model.
module tb_bit_serial_alu;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    bit_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } ref_t;

    function automatic ref_t model(input logic [WIDTH-1:0] ma,
                                   input logic [WIDTH-1:0] mb,
                                   input logic [3:0] mop);
        ref_t r;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH:0]   s;
        x = mop[3] ? ~ma : ma;
        y = mop[2] ? ~mb : mb;
        s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, mop[2]};
        r.c = s[WIDTH];
        r.v = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        case (mop[1:0])
            2'b00:   r.res = x & y;
            2'b01:   r.res = x | y;
            2'b10:   r.res = s[WIDTH-1:0];
            default: r.res = {{(WIDTH-1){1'b0}}, s[WIDTH-1] ^ r.v};
        endcase
        return r;
    endfunction

    // poke >= 0 pulses start with fresh operands that many cycles into RUN.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_, input logic [3:0] top,
                          input int poke);
        ref_t e;
        int n;
        e = model(ta, tb_, top);
        @(negedge clk);
        a = ta; b = tb_; op = top; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done && n < 100) begin
            if (n == poke) begin
                @(negedge clk);
                start = 1'b1; a = $urandom; b = $urandom; op = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, "_lat"}, n, WIDTH);
        check({tag, "_res"}, result, e.res);
        check({tag, "_zero"}, zero, e.res == '0);
        check({tag, "_cout"}, cout, e.c);
        check({tag, "_ovf"}, ovf, e.v);
        @(posedge clk); #1;
        check({tag, "_idle"}, {busy, done}, 2'b00);
        check({tag, "_hold"}, result, e.res);
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        int n;
        logic seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {busy, done, zero, cout, ovf}, 5'b00100);
        check("rst_res", result, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add", 32'h5, 32'h3, 4'b0010, -1);
        run_op("sub_ovf", 32'h8000_0000, 32'h1, 4'b0110, -1);
        run_op("slt_ovf", 32'h8000_0000, 32'h1, 4'b0111, -1);
        run_op("slt_eq", 32'h5, 32'h5, 4'b0111, -1);
        run_op("nor", 32'hF0F0_F0F0, 32'h0F0F_0000, 4'b1100, -1);
        run_op("and", 32'hFFFF_0000, 32'h00FF_FF00, 4'b0000, -1);
        run_op("sub_zero", 32'h1234_5678, 32'h1234_5678, 4'b0110, -1);
        run_op("ignore", 32'hCAFE_0001, 32'h0000_0FFF, 4'b0010, 10);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", $urandom, $urandom, 4'($urandom), -1);
        end

        // Held start: done pulses must be WIDTH+2 cycles apart.
        @(negedge clk);
        a = 32'h7; b = 32'h9; op = 4'b0010; start = 1'b1;
        t0 = -1; t1 = -1; t2 = -1; n = 0;
        while (t2 < 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                if (t0 < 0) t0 = cycle;
                else if (t1 < 0) t1 = cycle;
                else t2 = cycle;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held_gap1", t1 - t0, WIDTH + 2);
        check("held_gap2", t2 - t1, WIDTH + 2);
        check("held_res", result, 32'h10);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_drain", busy, 0);

        // Reset mid-run at index 16 aborts without a done pulse.
        @(negedge clk);
        a = 32'h1; b = 32'h1; op = 4'b0010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_res", result, 0);
        check("abort_zero", zero, 1);
        check("abort_flags", {done, cout, ovf}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("abort_nodone", seen, 0);
        run_op("after_rst", 32'hFFFF_FFFF, 32'h1, 4'b0010, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
